song_autoplayer: RTL and testbench

Demo and auto-accompaniment source for the piano datapath. It replays the built-in practice song (Twinkle Twinkle, 14 notes) as a timed stream of live-key events: a key ID plus a key-pressed level. Its outputs drive the same key_id/key_pressed interface that the practice and tone-generation blocks consume from the keypad. Each note is a press phase followed by a release gap, so every note gives downstream edge detectors a clean rising edge.

---
 rtl/piano_pkg.sv | 31 +++
 rtl/practice_song_rom.sv | 37 +++
 rtl/song_autoplayer.sv | 153 +++++++++++++++
 tb/tb_song_autoplayer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// piano_pkg: shared note IDs, song length, tempo codes and autoplayer states
// Revision: 1.0
// ---------------------------------------------------------------------------
package piano_pkg;

  localparam logic [3:0] NOTE_NONE = 4'd0;
  localparam logic [3:0] NOTE_C    = 4'd1;
  localparam logic [3:0] NOTE_D    = 4'd2;
  localparam logic [3:0] NOTE_E    = 4'd3;
  localparam logic [3:0] NOTE_F    = 4'd4;
  localparam logic [3:0] NOTE_G    = 4'd5;
  localparam logic [3:0] NOTE_A    = 4'd6;
  localparam logic [3:0] NOTE_B    = 4'd7;

  localparam int PRACTICE_SONG_LENGTH = 14;

  localparam logic [1:0] TEMPO_NORMAL = 2'b00;
  localparam logic [1:0] TEMPO_SLOW   = 2'b01;
  localparam logic [1:0] TEMPO_FAST   = 2'b10;

  typedef enum logic [1:0] {
    AP_IDLE  = 2'd0,
    AP_LEAD  = 2'd1,
    AP_PRESS = 2'd2,
    AP_GAP   = 2'd3
  } ap_state_e;

endpackage
`default_nettype wire

// File: rtl/practice_song_rom.sv
`default_nettype none
// ---------------------------------------------------------------------------
// practice_song_rom: index -> {note_id, beats} for the built-in practice song
// Revision: 1.0
// ---------------------------------------------------------------------------
module practice_song_rom
  import piano_pkg::*;
(
  input  logic [3:0] index_i,
  output logic [3:0] note_id_o,
  output logic [1:0] beats_o
);

  always_comb begin
    note_id_o = NOTE_NONE;
    beats_o   = 2'd0;
    case (index_i)
      4'd0:  begin note_id_o = NOTE_C; beats_o = 2'd1; end
      4'd1:  begin note_id_o = NOTE_C; beats_o = 2'd1; end
      4'd2:  begin note_id_o = NOTE_G; beats_o = 2'd1; end
      4'd3:  begin note_id_o = NOTE_G; beats_o = 2'd1; end
      4'd4:  begin note_id_o = NOTE_A; beats_o = 2'd1; end
      4'd5:  begin note_id_o = NOTE_A; beats_o = 2'd1; end
      4'd6:  begin note_id_o = NOTE_G; beats_o = 2'd2; end
      4'd7:  begin note_id_o = NOTE_F; beats_o = 2'd1; end
      4'd8:  begin note_id_o = NOTE_F; beats_o = 2'd1; end
      4'd9:  begin note_id_o = NOTE_E; beats_o = 2'd1; end
      4'd10: begin note_id_o = NOTE_E; beats_o = 2'd1; end
      4'd11: begin note_id_o = NOTE_D; beats_o = 2'd1; end
      4'd12: begin note_id_o = NOTE_D; beats_o = 2'd1; end
      4'd13: begin note_id_o = NOTE_C; beats_o = 2'd2; end
      default: begin note_id_o = NOTE_NONE; beats_o = 2'd0; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/song_autoplayer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// song_autoplayer: replays the practice song as timed key press/release events
// Revision: 1.0
// ---------------------------------------------------------------------------
module song_autoplayer
  import piano_pkg::*;
#(
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] tempo_sel,
  output logic [3:0] key_id,
  output logic       key_pressed,
  output logic [3:0] note_index,
  output logic       busy,
  output logic       song_done
);

  localparam int              CW       = $clog2(4 * BEAT_CYCLES + 1);
  localparam logic [CW-1:0]   C_BEAT   = CW'(BEAT_CYCLES);
  localparam logic [CW-1:0]   C_GAP    = CW'(GAP_CYCLES);
  localparam logic [CW-1:0]   C_ONE    = CW'(1);
  localparam logic [3:0]      C_LAST   = 4'(PRACTICE_SONG_LENGTH - 1);

  ap_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [1:0]    tempo_q, tempo_d;
  logic [3:0]    key_id_q, key_id_d;
  logic          kp_q, kp_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [1:0]    tempo_eff;
  logic [CW-1:0] beat_len;
  logic [CW-1:0] note_len;
  logic [3:0]    next_idx;
  logic [3:0]    rom_note;
  logic [1:0]    rom_beats;

  // In IDLE the beat length must reflect the tempo being latched this cycle.
  assign tempo_eff = (state_q == AP_IDLE) ? tempo_sel : tempo_q;
  assign next_idx  = (state_q == AP_GAP) ? (idx_q + 4'd1) : 4'd0;
  assign note_len  = (rom_beats == 2'd2) ? (beat_len << 1) : beat_len;

  always_comb begin
    case (tempo_eff)
      TEMPO_SLOW: beat_len = C_BEAT << 1;
      TEMPO_FAST: beat_len = C_BEAT >> 1;
      default:    beat_len = C_BEAT;
    endcase
  end

  practice_song_rom u_rom (
    .index_i   (next_idx),
    .note_id_o (rom_note),
    .beats_o   (rom_beats)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q - C_ONE;
    idx_d    = idx_q;
    tempo_d  = tempo_q;
    key_id_d = key_id_q;
    kp_d     = kp_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      AP_IDLE: begin
        cnt_d = '0;
        if (start && !stop) begin
          state_d = AP_LEAD;
          tempo_d = tempo_sel;
          cnt_d   = beat_len - C_ONE;
          idx_d   = 4'd0;
          busy_d  = 1'b1;
        end
      end
      AP_LEAD, AP_GAP: begin
        if (cnt_q == '0) begin
          if (state_q == AP_GAP && idx_q == C_LAST) begin
            state_d = AP_IDLE;
            cnt_d   = '0;
            idx_d   = 4'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d  = AP_PRESS;
            idx_d    = next_idx;
            key_id_d = rom_note;
            kp_d     = 1'b1;
            cnt_d    = note_len - C_GAP - C_ONE;
          end
        end
      end
      AP_PRESS: begin
        if (cnt_q == '0) begin
          state_d  = AP_GAP;
          key_id_d = NOTE_NONE;
          kp_d     = 1'b0;
          cnt_d    = C_GAP - C_ONE;
        end
      end
      default: state_d = AP_IDLE;
    endcase
    // Abort wins over any timer expiry and suppresses the completion pulse.
    if (stop && state_q != AP_IDLE) begin
      state_d  = AP_IDLE;
      cnt_d    = '0;
      idx_d    = 4'd0;
      key_id_d = NOTE_NONE;
      kp_d     = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= AP_IDLE;
      cnt_q    <= '0;
      idx_q    <= 4'd0;
      tempo_q  <= TEMPO_NORMAL;
      key_id_q <= NOTE_NONE;
      kp_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      tempo_q  <= tempo_d;
      key_id_q <= key_id_d;
      kp_q     <= kp_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign key_id      = key_id_q;
  assign key_pressed = kp_q;
  assign note_index  = idx_q;
  assign busy        = busy_q;
  assign song_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_song_autoplayer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_song_autoplayer: directed vector table plus hand sequences, BEAT=8, GAP=2
// ---------------------------------------------------------------------------
module tb_song_autoplayer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] tempo_sel = 2'b00;
  logic [3:0] key_id;
  logic       key_pressed;
  logic [3:0] note_index;
  logic       busy;
  logic       song_done;

  int n_tests = 0;
  int n_fail  = 0;

  song_autoplayer #(.BEAT_CYCLES(8), .GAP_CYCLES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .tempo_sel   (tempo_sel),
    .key_id      (key_id),
    .key_pressed (key_pressed),
    .note_index  (note_index),
    .busy        (busy),
    .song_done   (song_done)
  );

  always #5 clk = ~clk;

  // exp packs {key_pressed, key_id, note_index, busy, song_done}
  typedef struct {
    logic [1:0]  tempo;
    int          cyc;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] t, input int c, input logic kp,
                              input logic [3:0] kid, input logic [3:0] idx,
                              input logic b, input logic d);
    vec_t v;
    v.tempo = t;
    v.cyc   = c;
    v.exp   = {kp, kid, idx, b, d};
    return v;
  endfunction

  function automatic logic [10:0] obs();
    return {key_pressed, key_id, note_index, busy, song_done};
  endfunction

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual kp=%b id=%0d idx=%0d busy=%b done=%b, required kp=%b id=%0d idx=%0d busy=%b done=%b",
               name, act[10], act[9:6], act[5:2], act[1], act[0],
               exp[10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic chk1(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  // Starts a song in cycle 0 and walks to cycle ncyc, checking table rows.
  task automatic play(input logic [1:0] t, input int ncyc, input bit disturb, input bit counts);
    int   rises;
    int   dones;
    logic prev;
    rises = 0;
    dones = 0;
    prev  = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    tempo_sel = t;
    @(posedge clk); #1;
    for (int c = 1; c <= ncyc; c++) begin
      if (key_pressed && !prev) rises++;
      prev = key_pressed;
      if (song_done) dones++;
      foreach (vecs[i])
        if (vecs[i].tempo == t && vecs[i].cyc == c)
          chk($sformatf("t%0d_d%0d_c%0d", t, disturb, c), obs(), vecs[i].exp);
      if (c == ncyc) break;
      @(negedge clk);
      start = disturb && (c == 30);
      if (disturb) tempo_sel = c[1:0];
      @(posedge clk); #1;
    end
    start     = 1'b0;
    tempo_sel = 2'b00;
    if (counts) begin
      chk1($sformatf("rising_edges_t%0d", t), rises, 14);
      chk1($sformatf("done_pulses_t%0d", t), dones, 1);
    end
  endtask

  initial begin
    int bad;
    // tempo 00 (B=8)
    vecs.push_back(mk(2'b00,   1, 0, 0,  0, 1, 0));
    vecs.push_back(mk(2'b00,   8, 0, 0,  0, 1, 0));
    vecs.push_back(mk(2'b00,   9, 1, 1,  0, 1, 0));
    vecs.push_back(mk(2'b00,  14, 1, 1,  0, 1, 0));
    vecs.push_back(mk(2'b00,  15, 0, 0,  0, 1, 0));
    vecs.push_back(mk(2'b00,  17, 1, 1,  1, 1, 0));
    vecs.push_back(mk(2'b00,  25, 1, 5,  2, 1, 0));
    vecs.push_back(mk(2'b00,  40, 0, 0,  3, 1, 0));
    vecs.push_back(mk(2'b00,  57, 1, 5,  6, 1, 0));
    vecs.push_back(mk(2'b00,  70, 1, 5,  6, 1, 0));
    vecs.push_back(mk(2'b00,  71, 0, 0,  6, 1, 0));
    vecs.push_back(mk(2'b00,  73, 1, 4,  7, 1, 0));
    vecs.push_back(mk(2'b00, 121, 1, 1, 13, 1, 0));
    vecs.push_back(mk(2'b00, 134, 1, 1, 13, 1, 0));
    vecs.push_back(mk(2'b00, 135, 0, 0, 13, 1, 0));
    vecs.push_back(mk(2'b00, 136, 0, 0, 13, 1, 0));
    vecs.push_back(mk(2'b00, 137, 0, 0,  0, 0, 1));
    vecs.push_back(mk(2'b00, 138, 0, 0,  0, 0, 0));
    // tempo 01 (B=16)
    vecs.push_back(mk(2'b01,  16, 0, 0,  0, 1, 0));
    vecs.push_back(mk(2'b01,  17, 1, 1,  0, 1, 0));
    vecs.push_back(mk(2'b01,  31, 0, 0,  0, 1, 0));
    vecs.push_back(mk(2'b01,  33, 1, 1,  1, 1, 0));
    vecs.push_back(mk(2'b01, 272, 0, 0, 13, 1, 0));
    vecs.push_back(mk(2'b01, 273, 0, 0,  0, 0, 1));
    // tempo 10 (B=4)
    vecs.push_back(mk(2'b10,   4, 0, 0,  0, 1, 0));
    vecs.push_back(mk(2'b10,   5, 1, 1,  0, 1, 0));
    vecs.push_back(mk(2'b10,   6, 1, 1,  0, 1, 0));
    vecs.push_back(mk(2'b10,   7, 0, 0,  0, 1, 0));
    vecs.push_back(mk(2'b10,   9, 1, 1,  1, 1, 0));
    vecs.push_back(mk(2'b10,  29, 1, 5,  6, 1, 0));
    vecs.push_back(mk(2'b10,  68, 0, 0, 13, 1, 0));
    vecs.push_back(mk(2'b10,  69, 0, 0,  0, 0, 1));
    // tempo 11 behaves as 00
    vecs.push_back(mk(2'b11,   8, 0, 0,  0, 1, 0));
    vecs.push_back(mk(2'b11,   9, 1, 1,  0, 1, 0));
    vecs.push_back(mk(2'b11, 137, 0, 0,  0, 0, 1));

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (obs() !== 11'd0) bad++;
    end
    chk1("idle_after_reset_nonzero_cycles", bad, 0);

    play(2'b00, 139, 1'b0, 1'b1);
    play(2'b01, 275, 1'b0, 1'b1);
    play(2'b10,  71, 1'b0, 1'b1);
    play(2'b11, 139, 1'b0, 1'b1);
    play(2'b00, 139, 1'b1, 1'b1);

    // start and stop together in IDLE
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk); #1;
    chk("start_stop_idle", obs(), 11'd0);
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    @(posedge clk); #1;
    chk("start_stop_idle_next", obs(), 11'd0);

    // abort at cycle 40
    play(2'b00, 40, 1'b0, 1'b0);
    @(negedge clk);
    stop = 1'b1;
    @(posedge clk); #1;
    chk("stop_c41", obs(), 11'd0);
    @(negedge clk);
    stop = 1'b0;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (song_done || busy) bad++;
    end
    chk1("after_stop_done_or_busy", bad, 0);
    play(2'b00, 139, 1'b0, 1'b1);

    // asynchronous reset mid-press
    play(2'b00, 10, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_immediate", obs(), 11'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (obs() !== 11'd0) bad++;
    end
    chk1("idle_after_async_reset", bad, 0);
    play(2'b00, 139, 1'b0, 1'b1);

    // restart in the song_done cycle
    play(2'b10, 69, 1'b0, 1'b0);
    @(negedge clk);
    start     = 1'b1;
    tempo_sel = 2'b10;
    @(posedge clk); #1;
    chk("restart_c1", obs(), {1'b0, 4'd0, 4'd0, 1'b1, 1'b0});
    @(negedge clk);
    start     = 1'b0;
    tempo_sel = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    chk("restart_first_press", obs(), {1'b1, 4'd1, 4'd0, 1'b1, 1'b0});
    @(negedge clk);
    stop = 1'b1;
    @(posedge clk); #1;
    chk("stop_during_press", obs(), 11'd0);
    stop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
